// File: rtl/mem_access_unit.sv
// Memory stage: passes ALU results through and runs loads/stores byte-serially over an 8-bit RAM port.
// Optional alignment checking is compiled in with `define MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [4:0]            in_wd,
  input  logic                  in_wreg,
  input  logic [31:0]           in_wdata,
  input  logic                  in_mem_rd,
  input  logic                  in_mem_we,
  input  logic [1:0]            in_mem_size,
  input  logic                  in_mem_unsigned,
  input  logic [31:0]           in_store_data,
  output logic                  stall_req,
  output logic                  ram_req,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  input  logic                  ram_ready,
  output logic [4:0]            out_wd,
  output logic                  out_wreg,
  output logic [31:0]           out_wdata,
  output logic                  misalign_err
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                state;
  logic [1:0]            cnt;
  logic [RAM_ADDR_W-1:0] op_addr;
  logic [1:0]            op_size;
  logic                  op_unsigned;
  logic                  op_store;
  logic [4:0]            op_wd;
  logic                  op_wreg;
  logic [31:0]           op_data;
  logic [31:0]           load_buf;

  logic        consume;
  logic        is_mem;
  logic        misaligned;
  logic [1:0]  last_idx;
  logic [1:0]  cnt_next;
  logic [31:0] assembled;
  logic [31:0] load_result;

  always_comb begin
    consume  = in_valid && !stall_req;
    is_mem   = in_mem_rd || in_mem_we;
    cnt_next = cnt + 2'd1;
    case (op_size)
      2'd0:    last_idx = 2'd0;
      2'd1:    last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
    // The final byte is merged combinationally so the result is ready on the last edge.
    assembled = load_buf;
    assembled[8*cnt +: 8] = ram_din;
    case (op_size)
      2'd0:    load_result = op_unsigned ? {24'd0, assembled[7:0]}
                                         : {{24{assembled[7]}}, assembled[7:0]};
      2'd1:    load_result = op_unsigned ? {16'd0, assembled[15:0]}
                                         : {{16{assembled[15]}}, assembled[15:0]};
      default: load_result = assembled;
    endcase
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = (in_mem_size == 2'd1 && in_wdata[0]) ||
                 (in_mem_size[1] && in_wdata[1:0] != 2'b00);
`else
    misaligned = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      op_addr      <= '0;
      op_size      <= 2'd0;
      op_unsigned  <= 1'b0;
      op_store     <= 1'b0;
      op_wd        <= 5'd0;
      op_wreg      <= 1'b0;
      op_data      <= 32'd0;
      load_buf     <= 32'd0;
      stall_req    <= 1'b0;
      ram_req      <= 1'b0;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_dout     <= 8'd0;
      out_wd       <= 5'd0;
      out_wreg     <= 1'b0;
      out_wdata    <= 32'd0;
      misalign_err <= 1'b0;
    end else begin
      out_wd       <= 5'd0;
      out_wreg     <= 1'b0;
      out_wdata    <= 32'd0;
      misalign_err <= 1'b0;
      case (state)
        IDLE: begin
          if (consume) begin
            if (is_mem && misaligned) begin
              misalign_err <= 1'b1;
            end else if (is_mem) begin
              state       <= XFER;
              cnt         <= 2'd0;
              op_addr     <= in_wdata[RAM_ADDR_W-1:0];
              op_size     <= in_mem_size;
              op_unsigned <= in_mem_unsigned;
              op_store    <= in_mem_we;
              op_wd       <= in_wd;
              op_wreg     <= in_wreg;
              op_data     <= in_store_data;
              load_buf    <= 32'd0;
              stall_req   <= 1'b1;
              ram_req     <= 1'b1;
              ram_addr    <= in_wdata[RAM_ADDR_W-1:0];
              ram_we      <= in_mem_we;
              ram_dout    <= in_store_data[7:0];
            end else begin
              out_wd    <= in_wd;
              out_wreg  <= in_wreg;
              out_wdata <= in_wdata;
            end
          end
        end
        XFER: begin
          if (ram_ready) begin
            if (!op_store) load_buf <= assembled;
            if (cnt == last_idx) begin
              state     <= IDLE;
              cnt       <= 2'd0;
              stall_req <= 1'b0;
              ram_req   <= 1'b0;
              ram_addr  <= '0;
              ram_we    <= 1'b0;
              ram_dout  <= 8'd0;
              if (!op_store) begin
                out_wd    <= op_wd;
                out_wreg  <= op_wreg;
                out_wdata <= load_result;
              end
            end else begin
              cnt      <= cnt_next;
              ram_addr <= op_addr + RAM_ADDR_W'(cnt_next);
              ram_dout <= 8'(op_data >> {cnt_next, 3'b000});
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan items plus randomized ALU/load/store traffic
// checked against a byte-array memory model.
module tb_mem_access_unit;
  localparam int AW    = 17;
  localparam int MEMSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [4:0]    in_wd;
  logic          in_wreg;
  logic [31:0]   in_wdata;
  logic          in_mem_rd;
  logic          in_mem_we;
  logic [1:0]    in_mem_size;
  logic          in_mem_unsigned;
  logic [31:0]   in_store_data;
  logic          stall_req;
  logic          ram_req;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_dout;
  logic [7:0]    ram_din;
  logic          ram_ready;
  logic [4:0]    out_wd;
  logic          out_wreg;
  logic [31:0]   out_wdata;
  logic          misalign_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem     [MEMSZ];
  bit         wr      [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];
  int         write_count = 0;

  mem_access_unit #(.RAM_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_wd(in_wd), .in_wreg(in_wreg),
    .in_wdata(in_wdata), .in_mem_rd(in_mem_rd), .in_mem_we(in_mem_we),
    .in_mem_size(in_mem_size), .in_mem_unsigned(in_mem_unsigned),
    .in_store_data(in_store_data), .stall_req(stall_req), .ram_req(ram_req),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_ready(ram_ready), .out_wd(out_wd), .out_wreg(out_wreg), .out_wdata(out_wdata),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  // Background RAM contents are a fixed function of the address until a byte is written.
  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 37) ^ (a >> 7) ^ 8'h5A);
  endfunction

  assign ram_din = wr[ram_addr] ? mem[ram_addr] : init_byte(int'(ram_addr));

  always @(posedge clk) begin
    if (ram_req && ram_ready && ram_we) begin
      mem[ram_addr] <= ram_dout;
      wr[ram_addr]  <= 1'b1;
      write_count   <= write_count + 1;
    end
  end

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [AW-1:0] base, input logic [1:0] size,
                                             input logic uns);
    int n = nbytes(size);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(int'(base) + i) % MEMSZ]) << (8 * i));
    if (n == 1 && !uns && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && !uns && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                               input logic rd, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] sdata);
    in_valid        = 1'b1;
    in_wd           = wd;
    in_wreg         = wreg;
    in_wdata        = wdata;
    in_mem_rd       = rd;
    in_mem_we       = we;
    in_mem_size     = size;
    in_mem_unsigned = uns;
    in_store_data   = sdata;
  endtask

  task automatic idleInputs();
    in_valid        = 1'b0;
    in_wd           = 5'd0;
    in_wreg         = 1'b0;
    in_wdata        = 32'd0;
    in_mem_rd       = 1'b0;
    in_mem_we       = 1'b0;
    in_mem_size     = 2'd0;
    in_mem_unsigned = 1'b0;
    in_store_data   = 32'd0;
  endtask

  // Called at a negedge; leaves the instruction applied so calls can run back to back.
  task automatic aluOp(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
    applyStimulus(wd, wreg, wdata, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("alu_wd", out_wd, wd);
    checkOutput("alu_wreg", out_wreg, wreg);
    checkOutput("alu_wdata", out_wdata, wdata);
    checkOutput("alu_stall", stall_req, 0);
  endtask

  // ready_pct: 100 = always ready, <0 = toggle 1,0,1,..., otherwise random percentage.
  task automatic memOp(input logic is_store, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] sdata, input logic [4:0] wd,
                       input int ready_pct, output logic [31:0] got);
    int n = nbytes(size);
    logic [AW-1:0] base = addr[AW-1:0];
    logic [AW-1:0] ea;
    logic [31:0] exp_val;
    bit mis;
    int done = 0;
    int cycles = 0;
    mis = (size == 2'd1 && addr[0]) || (size[1] && addr[1:0] != 2'b00);
    exp_val = is_store ? 32'd0 : model_load(base, size, uns);
    applyStimulus(wd, 1'b1, addr, !is_store, is_store, size, uns, sdata);
    @(posedge clk);
    @(negedge clk);
    idleInputs();
`ifdef MEM_ALIGN_CHECK_EN
    if (mis) begin
      checkOutput("mis_err", misalign_err, 1);
      checkOutput("mis_stall", stall_req, 0);
      checkOutput("mis_req", ram_req, 0);
      checkOutput("mis_wreg", out_wreg, 0);
      got = out_wdata;
      @(posedge clk);
      @(negedge clk);
      checkOutput("mis_err_pulse", misalign_err, 0);
      return;
    end
`endif
    checkOutput("no_mis_err", misalign_err, 0);
    while (stall_req && cycles < 200) begin
      ea = base + AW'(done);
      checkOutput("ram_req", ram_req, 1);
      checkOutput("ram_addr", 32'(ram_addr), 32'(ea));
      checkOutput("ram_we", ram_we, is_store);
      if (is_store) checkOutput("ram_dout", ram_dout, 32'(8'(sdata >> (8 * done))));
      checkOutput("busy_bubble", out_wreg, 0);
      if (ready_pct >= 100)   ram_ready = 1'b1;
      else if (ready_pct < 0) ram_ready = (cycles % 2 == 0);
      else                    ram_ready = ($urandom_range(99) < ready_pct);
      @(posedge clk);
      if (ram_ready) begin
        if (is_store) ref_mem[ea] = 8'(sdata >> (8 * done));
        done++;
      end
      cycles++;
      @(negedge clk);
    end
    ram_ready = 1'b0;
    checkOutput("xfer_timeout", (cycles < 200), 1);
    checkOutput("xfer_bytes", done, n);
    if (ready_pct >= 100)   checkOutput("stall_cycles", cycles, n);
    else if (ready_pct < 0) checkOutput("stall_cycles", cycles, 2 * n - 1);
    checkOutput("res_wd", out_wd, is_store ? 5'd0 : wd);
    checkOutput("res_wreg", out_wreg, !is_store);
    checkOutput("res_wdata", out_wdata, exp_val);
    got = out_wdata;
    if (is_store) begin
      for (int i = 0; i < n; i++) begin
        ea = base + AW'(i);
        checkOutput("store_byte", {wr[ea], mem[ea]}, {1'b1, ref_mem[ea]});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] got;
    logic [31:0] addr;
    int base_cnt;
    for (int i = 0; i < MEMSZ; i++) ref_mem[i] = init_byte(i);
    idleInputs();
    ram_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_stall", stall_req, 0);
    checkOutput("rst_req", ram_req, 0);
    checkOutput("rst_addr", 32'(ram_addr), 0);
    checkOutput("rst_we", ram_we, 0);
    checkOutput("rst_dout", ram_dout, 0);
    checkOutput("rst_out", {out_wd, out_wreg, out_wdata}, 0);
    checkOutput("rst_mis", misalign_err, 0);
    rst = 1'b0;

    aluOp(5'd5, 1'b1, 32'h0000_1234);
    idleInputs();
    @(posedge clk);
    @(negedge clk);
    checkOutput("idle_bubble", {out_wd, out_wreg, out_wdata}, 0);

    for (int i = 0; i < 20; i++) aluOp(5'($urandom), 1'($urandom), $urandom);
    idleInputs();

    memOp(1'b1, 32'h0000_0100, 2'd2, 1'b0, 32'h1234_5678, 5'd0, 100, got);
    memOp(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, 5'd7, 100, got);
    checkOutput("lw_value", got, 32'h1234_5678);

    memOp(1'b1, 32'h0000_0180, 2'd0, 1'b0, 32'h0000_0080, 5'd0, 100, got);
    memOp(1'b0, 32'h0000_0180, 2'd0, 1'b0, 32'd0, 5'd9, 100, got);
    checkOutput("lb_value", got, 32'hFFFF_FF80);
    memOp(1'b0, 32'h0000_0180, 2'd0, 1'b1, 32'd0, 5'd9, 100, got);
    checkOutput("lbu_value", got, 32'h0000_0080);

    memOp(1'b1, 32'h0000_0202, 2'd1, 1'b0, 32'hAABB_CCDD, 5'd0, -1, got);
    checkOutput("sh_byte0", mem[17'h202], 8'hDD);
    checkOutput("sh_byte1", mem[17'h203], 8'hCC);

    // Reset after the second byte of a word store; RAM is held off on the reset edge.
    base_cnt = write_count;
    applyStimulus(5'd0, 1'b1, 32'h0000_0300, 1'b0, 1'b1, 2'd2, 1'b0, 32'hCAFE_BABE);
    ram_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idleInputs();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ram_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstx_req", ram_req, 0);
    checkOutput("rstx_stall", stall_req, 0);
    checkOutput("rstx_out", {out_wd, out_wreg, out_wdata}, 0);
    checkOutput("rstx_writes", write_count - base_cnt, 2);
    checkOutput("rstx_byte0", {wr[17'h300], mem[17'h300]}, {1'b1, 8'hBE});
    checkOutput("rstx_byte1", {wr[17'h301], mem[17'h301]}, {1'b1, 8'hBA});
    checkOutput("rstx_byte2", wr[17'h302], 0);
    ref_mem[17'h300] = 8'hBE;
    ref_mem[17'h301] = 8'hBA;

    memOp(1'b0, 32'h0000_0101, 2'd2, 1'b0, 32'd0, 5'd3, 100, got);
    memOp(1'b0, 32'h8001_FFFE, 2'd2, 1'b0, 32'd0, 5'd4, 100, got);

    for (int i = 0; i < 40; i++) begin
      addr = {$urandom_range(255), 8'h00, 16'h0000} | 32'(17'h0400 + $urandom_range(63));
      case ($urandom_range(2))
        0:       aluOp(5'($urandom), 1'($urandom), $urandom);
        1:       memOp(1'b0, addr, 2'($urandom), 1'($urandom), 32'd0, 5'($urandom), 70, got);
        default: memOp(1'b1, addr, 2'($urandom), 1'b0, $urandom, 5'd0, 70, got);
      endcase
    end
    idleInputs();
    @(posedge clk);
    @(negedge clk);
    checkOutput("final_bubble", {out_wd, out_wreg, out_wdata}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
